// File: rtl/mem_lsu.sv
// mem_lsu: single-outstanding load/store unit in front of a 32-bit synchronous RAM
// with active-low byte-lane selects. Handles byte/half/word accesses, alignment and
// range checking, store-data replication and load-data alignment/extension.
module mem_lsu #(
    parameter int unsigned RAM_AW = 13
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [31:0]       resp_rdata,
    output logic              resp_err,
    output logic [RAM_AW-1:0] ram_address,
    output logic [31:0]       ram_din,
    output logic              ram_rnw,
    output logic [3:0]        ram_cs_b,
    input  logic [31:0]       ram_dout
);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RDATA,
        RESP
    } state_t;

    state_t state_q, state_d;

    logic              we_q;
    logic [1:0]        size_q;
    logic              signed_q;
    logic [1:0]        lane_q;
    logic [3:0]        mask_q;
    logic [RAM_AW-1:0] ram_address_q;
    logic [31:0]       ram_din_q;
    logic [31:0]       resp_rdata_q;
    logic              resp_err_q;

    logic              accept;
    logic              req_err;
    logic [3:0]        req_mask;
    logic [31:0]       req_din;
    logic [31:0]       shifted;
    logic [31:0]       load_data;

    assign accept = req_valid && (state_q == IDLE);

    // Decode the incoming request: legality, lane mask and replicated store data
    always_comb begin
        req_err  = 1'b0;
        req_mask = 4'b1111;
        req_din  = req_wdata;
        case (req_size)
            2'b00: begin
                req_mask = ~(4'b0001 << req_addr[1:0]);
                req_din  = {4{req_wdata[7:0]}};
            end
            2'b01: begin
                req_err  = req_addr[0];
                req_mask = req_addr[1] ? 4'b0011 : 4'b1100;
                req_din  = {2{req_wdata[15:0]}};
            end
            2'b10: begin
                req_err  = |req_addr[1:0];
                req_mask = 4'b0000;
            end
            default: begin
                req_err  = 1'b1;
            end
        endcase
        if (|req_addr[31:RAM_AW+2]) begin
            req_err = 1'b1;
        end
    end

    // Select, right-justify and extend the addressed lane(s) of the RAM read data
    always_comb begin
        shifted   = ram_dout >> {lane_q, 3'b000};
        load_data = ram_dout;
        case (size_q)
            2'b00:   load_data = {{24{signed_q & shifted[7]}}, shifted[7:0]};
            2'b01:   load_data = {{16{signed_q & shifted[15]}}, shifted[15:0]};
            default: load_data = ram_dout;
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (req_valid) state_d = req_err ? RESP : ACCESS;
            ACCESS:  state_d = we_q ? RESP : RDATA;
            RDATA:   state_d = RESP;
            RESP:    if (resp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Request capture, RAM-side registers and response data
    // RAM address/data/mask are only loaded for legal requests so they hold otherwise
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            we_q          <= 1'b0;
            size_q        <= 2'b00;
            signed_q      <= 1'b0;
            lane_q        <= 2'b00;
            mask_q        <= 4'b1111;
            ram_address_q <= '0;
            ram_din_q     <= '0;
            resp_rdata_q  <= '0;
            resp_err_q    <= 1'b0;
        end else begin
            if (accept) begin
                we_q         <= req_we;
                size_q       <= req_size;
                signed_q     <= req_signed;
                lane_q       <= req_addr[1:0];
                resp_err_q   <= req_err;
                resp_rdata_q <= '0;
                if (!req_err) begin
                    ram_address_q <= req_addr[RAM_AW+1:2];
                    ram_din_q     <= req_din;
                    mask_q        <= req_mask;
                end
            end
            if (state_q == RDATA) begin
                resp_rdata_q <= load_data;
            end
        end
    end

    // Output decode from state
    always_comb begin
        req_ready   = (state_q == IDLE);
        resp_valid  = (state_q == RESP);
        ram_cs_b    = (state_q == ACCESS) ? mask_q : 4'b1111;
        ram_rnw     = (state_q == ACCESS) ? !we_q : 1'b1;
        ram_address = ram_address_q;
        ram_din     = ram_din_q;
        resp_rdata  = resp_rdata_q;
        resp_err    = resp_err_q;
    end

endmodule

// File: tb/tb_mem_lsu.sv
// tb_mem_lsu: directed and random load/store traffic against a byte-array reference
// memory, with a byte-lane synchronous RAM model attached to the RAM port.
module tb_mem_lsu;

    localparam int unsigned AW        = 13;
    localparam int unsigned MEM_BYTES = 4 << AW;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic          req_we = 1'b0;
    logic [1:0]    req_size = 2'b00;
    logic          req_signed = 1'b0;
    logic [31:0]   req_addr = '0;
    logic [31:0]   req_wdata = '0;
    logic          resp_valid;
    logic          resp_ready = 1'b0;
    logic [31:0]   resp_rdata;
    logic          resp_err;
    logic [AW-1:0] ram_address;
    logic [31:0]   ram_din;
    logic          ram_rnw;
    logic [3:0]    ram_cs_b;
    logic [31:0]   ram_dout = '0;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] ram     [0:(1<<AW)-1];
    logic [7:0]  ref_mem [0:MEM_BYTES-1];

    always #5 clk = ~clk;

    mem_lsu #(.RAM_AW(AW)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_we      (req_we),
        .req_size    (req_size),
        .req_signed  (req_signed),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .resp_valid  (resp_valid),
        .resp_ready  (resp_ready),
        .resp_rdata  (resp_rdata),
        .resp_err    (resp_err),
        .ram_address (ram_address),
        .ram_din     (ram_din),
        .ram_rnw     (ram_rnw),
        .ram_cs_b    (ram_cs_b),
        .ram_dout    (ram_dout)
    );

    // Synchronous RAM: byte-lane writes, registered read of the presented address
    always @(posedge clk) begin
        for (int n = 0; n < 4; n++) begin
            if (!ram_cs_b[n] && !ram_rnw) ram[ram_address][8*n +: 8] <= ram_din[8*n +: 8];
        end
        ram_dout <= ram[ram_address];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic int unsigned nbytes(input logic [1:0] s);
        return (s == 2'd0) ? 1 : (s == 2'd1) ? 2 : 4;
    endfunction

    function automatic bit is_err(input logic [1:0] s, input logic [31:0] a);
        if (s == 2'd3) return 1'b1;
        if ((a % nbytes(s)) != 0) return 1'b1;
        if (a >= MEM_BYTES) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [3:0] exp_mask(input logic [1:0] s, input logic [31:0] a);
        logic [3:0] m = 4'hF;
        for (int unsigned n = 0; n < 4; n++) begin
            int unsigned b = (a & ~32'd3) + n;
            if (b >= a && b < a + nbytes(s)) m[n] = 1'b0;
        end
        return m;
    endfunction

    function automatic logic [31:0] exp_din(input logic [1:0] s, input logic [31:0] w);
        logic [31:0] d;
        for (int unsigned n = 0; n < 4; n++) d[8*n +: 8] = 8'(w >> (8 * (n % nbytes(s))));
        return d;
    endfunction

    function automatic logic [31:0] exp_load(input logic [1:0] s, input logic sg, input logic [31:0] a);
        logic [31:0] v = '0;
        int unsigned nb = nbytes(s);
        for (int unsigned i = 0; i < nb; i++) v |= 32'(ref_mem[a + i]) << (8 * i);
        if (sg && nb < 4 && v[8*nb-1]) v |= 32'hFFFF_FFFF << (8 * nb);
        return v;
    endfunction

    task automatic model_store(input logic [1:0] s, input logic [31:0] a, input logic [31:0] w);
        for (int unsigned i = 0; i < nbytes(s); i++) ref_mem[a + i] = 8'(w >> (8 * i));
    endtask

    // One complete transaction with per-cycle checks and an optional response stall
    task automatic xact(input logic we, input logic [1:0] s, input logic sg,
                        input logic [31:0] a, input logic [31:0] w, input int stall);
        logic        err;
        logic [31:0] exp_rd;
        err    = is_err(s, a);
        exp_rd = '0;
        @(negedge clk);
        chk("req_ready_idle", req_ready, 1);
        req_we = we; req_size = s; req_signed = sg; req_addr = a; req_wdata = w;
        req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        if (err) begin
            chk("err_valid", resp_valid, 1);
            chk("err_flag", resp_err, 1);
            chk("err_rdata", resp_rdata, 0);
            chk("err_cs", ram_cs_b, 4'hF);
        end else begin
            chk("acc_valid", resp_valid, 0);
            chk("acc_cs", ram_cs_b, exp_mask(s, a));
            chk("acc_rnw", ram_rnw, !we);
            chk("acc_addr", ram_address, (a >> 2) & ((1 << AW) - 1));
            if (we) chk("acc_din", ram_din, exp_din(s, w));
            @(negedge clk);
            if (we) begin
                model_store(s, a, w);
                chk("st_valid", resp_valid, 1);
                chk("st_err", resp_err, 0);
                chk("st_rdata", resp_rdata, 0);
                chk("st_cs", ram_cs_b, 4'hF);
            end else begin
                exp_rd = exp_load(s, sg, a);
                chk("rd_valid", resp_valid, 0);
                chk("rd_cs", ram_cs_b, 4'hF);
                @(negedge clk);
                chk("ld_valid", resp_valid, 1);
                chk("ld_err", resp_err, 0);
                chk("ld_rdata", resp_rdata, exp_rd);
            end
        end
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            chk("stall_valid", resp_valid, 1);
            chk("stall_rdata", resp_rdata, exp_rd);
            chk("stall_err", resp_err, err);
            chk("stall_ready", req_ready, 0);
            chk("stall_cs", ram_cs_b, 4'hF);
        end
        resp_ready = 1'b1;
        @(posedge clk);
        #1 resp_ready = 1'b0;
        @(negedge clk);
        chk("post_valid", resp_valid, 0);
        chk("post_ready", req_ready, 1);
    endtask

    initial begin
        logic        we, sg;
        logic [1:0]  s;
        logic [31:0] a;
        int unsigned r;

        for (int unsigned i = 0; i < (1 << AW); i++) ram[i] = '0;
        for (int unsigned i = 0; i < MEM_BYTES; i++) ref_mem[i] = '0;

        // Reset values before any clock edge
        #2 rst = 1'b1;
        #1;
        chk("rst_req_ready", req_ready, 1);
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_resp_err", resp_err, 0);
        chk("rst_resp_rdata", resp_rdata, 0);
        chk("rst_cs", ram_cs_b, 4'hF);
        chk("rst_rnw", ram_rnw, 1);
        chk("rst_addr", ram_address, 0);
        chk("rst_din", ram_din, 0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b0;

        // Word store/load
        xact(1, 2'd2, 0, 32'h10, 32'hDEADBEEF, 0);
        xact(0, 2'd2, 0, 32'h10, 32'h0, 0);
        chk("word_ld_const", resp_rdata, 32'hDEADBEEF);
        // Byte store and signed/unsigned/word readback
        xact(1, 2'd0, 0, 32'h13, 32'h000000A5, 0);
        xact(0, 2'd0, 1, 32'h13, 32'h0, 0);
        chk("sbyte_const", resp_rdata, 32'hFFFFFFA5);
        xact(0, 2'd0, 0, 32'h13, 32'h0, 0);
        chk("ubyte_const", resp_rdata, 32'h000000A5);
        xact(0, 2'd2, 0, 32'h10, 32'h0, 0);
        chk("merge_const", resp_rdata, 32'hA5ADBEEF);
        // Halfword store and signed readback
        xact(1, 2'd1, 0, 32'h12, 32'h00008001, 0);
        xact(0, 2'd1, 1, 32'h12, 32'h0, 0);
        chk("shalf_const", resp_rdata, 32'hFFFF8001);
        // Error cases, then memory unchanged
        xact(1, 2'd1, 0, 32'h11, 32'h11111111, 0);
        xact(1, 2'd2, 0, 32'h12, 32'h22222222, 0);
        xact(1, 2'd3, 0, 32'h10, 32'h33333333, 0);
        xact(1, 2'd2, 0, 32'h8000, 32'h44444444, 0);
        xact(0, 2'd2, 0, 32'h10, 32'h0, 0);
        chk("unchanged_const", resp_rdata, 32'h8001BEEF);
        // Long response stall
        xact(0, 2'd2, 0, 32'h10, 32'h0, 5);
        xact(0, 2'd3, 0, 32'h10, 32'h0, 5);

        // Reset in the ACCESS cycle of a store
        @(negedge clk);
        req_we = 1; req_size = 2'd2; req_signed = 0; req_addr = 32'h20; req_wdata = 32'h12345678;
        req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        chk("abort_acc_cs", ram_cs_b, 4'h0);
        #1 rst = 1'b1;
        #1;
        chk("abort_cs", ram_cs_b, 4'hF);
        chk("abort_rnw", ram_rnw, 1);
        chk("abort_ready", req_ready, 1);
        chk("abort_valid", resp_valid, 0);
        @(posedge clk);
        @(negedge clk) rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("abort_no_resp", resp_valid, 0);
        end
        xact(0, 2'd2, 0, 32'h20, 32'h0, 0);
        chk("abort_mem_const", resp_rdata, 32'h0);

        // Random traffic
        for (int k = 0; k < 300; k++) begin
            we = 1'($urandom);
            sg = 1'($urandom);
            s  = 2'($urandom);
            r  = $urandom_range(0, 9);
            if (r < 8)       a = $urandom_range(0, 63);
            else if (r == 8) a = MEM_BYTES - 8 + $urandom_range(0, 7);
            else             a = ($urandom_range(0, 1) != 0) ? MEM_BYTES + $urandom_range(0, 63) : $urandom;
            xact(we, s, sg, a, $urandom, $urandom_range(0, 2));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
